// File: rtl/ca6_pkg.sv
// rtl/ca6_pkg.sv - shared types and defaults for the ca6 engine scheduler
// Contents: q8_8_t operand type, sched_state_e FSM encoding, default START_CYCLES/TIMEOUT.
package ca6_pkg;

    typedef logic [15:0] q8_8_t;

    typedef enum logic [1:0] {
        SCHED_IDLE  = 2'd0,
        SCHED_START = 2'd1,
        SCHED_WAIT  = 2'd2,
        SCHED_RESP  = 2'd3
    } sched_state_e;

    localparam int DEF_START_CYCLES = 2;
    localparam int DEF_TIMEOUT      = 64;

endpackage

// File: rtl/ca6_sched_if.sv
// rtl/ca6_sched_if.sv - requester-side and engine-side bundles for ca6_sched
// ca6_req_if: req_valid/req_x/req_y in, req_ready/rsp_valid/rsp_ans/rsp_err out (slave = scheduler).
// ca6_eng_if: eng_start/eng_x/eng_y to the engine, eng_ans/eng_done back (master = scheduler).
interface ca6_req_if #(
    parameter int N = 4
);
    import ca6_pkg::*;

    logic [N-1:0]        req_valid;
    q8_8_t [N-1:0]       req_x;
    logic [N-1:0][7:0]   req_y;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        rsp_valid;
    q8_8_t               rsp_ans;
    logic                rsp_err;

    modport master (
        output req_valid, req_x, req_y,
        input  req_ready, rsp_valid, rsp_ans, rsp_err
    );

    modport slave (
        input  req_valid, req_x, req_y,
        output req_ready, rsp_valid, rsp_ans, rsp_err
    );
endinterface

interface ca6_eng_if;
    import ca6_pkg::*;

    logic        eng_start;
    q8_8_t       eng_x;
    logic [7:0]  eng_y;
    q8_8_t       eng_ans;
    logic        eng_done;

    modport master (
        output eng_start, eng_x, eng_y,
        input  eng_ans, eng_done
    );

    modport slave (
        input  eng_start, eng_x, eng_y,
        output eng_ans, eng_done
    );
endinterface

// File: rtl/ca6_sched_rr_arbiter.sv
// rtl/ca6_sched_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
// Ports: req (N) in, rr_ptr in; grant (N, one-hot or zero) out, idx (encoded grant) out.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW:0]   cand;
    logic [IW-1:0] cand_idx;
    logic          found;

    // Scan N positions starting at rr_ptr; the extra bit keeps ptr+k from
    // overflowing before the wrap subtraction.
    always_comb begin
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand = {1'b0, rr_ptr} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            cand_idx = cand[IW-1:0];
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ca6_sched.sv
// rtl/ca6_sched.sv - round-robin scheduler sharing one ca6 engine among N requesters
// Ports: clk, rst_n (sync, active-low); req_bus (ca6_req_if.slave) requester side;
//        eng_bus (ca6_eng_if.master) engine side.
module ca6_sched
    import ca6_pkg::*;
#(
    parameter int N            = 4,
    parameter int START_CYCLES = DEF_START_CYCLES,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    ca6_req_if.slave   req_bus,
    ca6_eng_if.master  eng_bus
);

    localparam int IW = $clog2(N);
    localparam int SW = $clog2(START_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = SCHED_IDLE;
    localparam logic [1:0] ST_START = SCHED_START;
    localparam logic [1:0] ST_WAIT  = SCHED_WAIT;
    localparam logic [1:0] ST_RESP  = SCHED_RESP;

    logic [1:0]    state_q,  state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] id_q,     id_d;
    q8_8_t         x_q,      x_d;
    logic [7:0]    y_q,      y_d;
    q8_8_t         ans_q,    ans_d;
    logic          err_q,    err_d;
    logic          done_q,   done_d;
    logic [SW-1:0] scnt_q,   scnt_d;
    logic [WW-1:0] wcnt_q,   wcnt_d;

    logic [N-1:0]  arb_grant;
    logic [IW-1:0] arb_idx;
    logic          accept;
    logic          done_edge;

    rr_arbiter #(.N(N)) u_arb (
        .req    (req_bus.req_valid),
        .rr_ptr (rr_ptr_q),
        .grant  (arb_grant),
        .idx    (arb_idx)
    );

    // Grant is gated by rst_n so nothing is accepted on a reset edge.
    assign accept    = (state_q == ST_IDLE) && rst_n && (|arb_grant);
    // done_q tracks eng_done in every state, so a level left high from the
    // previous job (or raised during START) never looks like a new edge.
    assign done_edge = eng_bus.eng_done && !done_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        x_d      = x_q;
        y_d      = y_q;
        ans_d    = ans_q;
        err_d    = err_q;
        done_d   = eng_bus.eng_done;
        scnt_d   = scnt_q;
        wcnt_d   = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d    = arb_idx;
                    x_d     = req_bus.req_x[arb_idx];
                    y_d     = req_bus.req_y[arb_idx];
                    scnt_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (scnt_q == SW'(START_CYCLES - 1)) begin
                    wcnt_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (done_edge) begin
                    ans_d   = eng_bus.eng_ans;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wcnt_q == WW'(TIMEOUT)) begin
                    ans_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (wcnt_q != '1) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                rr_ptr_d = (id_q == IW'(N - 1)) ? '0 : id_q + 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            ans_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            scnt_q   <= '0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            x_q      <= x_d;
            y_q      <= y_d;
            ans_q    <= ans_d;
            err_q    <= err_d;
            done_q   <= done_d;
            scnt_q   <= scnt_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign req_bus.req_ready = accept ? arb_grant : '0;
    assign req_bus.rsp_valid = (state_q == ST_RESP) ? (N'(1) << id_q) : '0;
    assign req_bus.rsp_ans   = (state_q == ST_RESP) ? ans_q : '0;
    assign req_bus.rsp_err   = (state_q == ST_RESP) && err_q;

    assign eng_bus.eng_start = (state_q == ST_START);
    assign eng_bus.eng_x     = x_q;
    assign eng_bus.eng_y     = y_q;

endmodule

// File: tb/tb_ca6_sched.sv
// tb/tb_ca6_sched.sv - self-checking bench for ca6_sched with an engine stub and reference model
module tb_ca6_sched;
    import ca6_pkg::*;

    localparam int N  = 4;
    localparam int SC = 2;
    localparam int TO = 64;
    localparam int M_PULSE  = 0;
    localparam int M_STICKY = 1;
    localparam int M_NEVER  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ca6_req_if #(.N(N)) rq();
    ca6_eng_if          eg();

    ca6_sched #(.N(N), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_bus (rq),
        .eng_bus (eg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine stub: captures operands while eng_start is high, raises done
    // 10 cycles after eng_start falls (pulse or sticky), or never.
    int    stub_mode = M_PULSE;
    bit    stub_run  = 1'b0;
    int    stub_cnt  = 0;
    q8_8_t stub_ans;

    initial begin
        eg.eng_done = 1'b0;
        eg.eng_ans  = '0;
    end

    always @(posedge clk) begin
        #2;
        if (!rst_n) begin
            stub_run    = 1'b0;
            eg.eng_done = 1'b0;
        end else if (eg.eng_start) begin
            stub_run    = 1'b1;
            stub_cnt    = 0;
            eg.eng_done = 1'b0;
            eg.eng_ans  = q8_8_t'($urandom);
            stub_ans    = eg.eng_x ^ {8'h00, eg.eng_y};
        end else begin
            if (stub_mode == M_PULSE && eg.eng_done) eg.eng_done = 1'b0;
            if (stub_run) begin
                if (stub_cnt == 9) begin
                    stub_run = 1'b0;
                    if (stub_mode != M_NEVER) begin
                        eg.eng_done = 1'b1;
                        eg.eng_ans  = stub_ans;
                    end
                end else begin
                    stub_cnt++;
                end
            end
        end
    end

    // Reference model: one job at a time, round-robin from m_ptr.
    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         m_ptr = 0;
    bit         m_busy = 1'b0;
    int         m_id = 0;
    q8_8_t      m_x = '0;
    logic [7:0] m_y = '0;
    q8_8_t      m_exp = '0;
    int         st_run = 0;
    int         fall_cyc = 0;
    int         acc_count = 0;
    int         rsp_count = 0;
    int         last_acc_id = 0;
    bit         acc_flag = 1'b0;
    logic [N-1:0] last_rsp_valid = '0;
    q8_8_t      last_ans = '0;
    logic       last_err = 1'b0;
    int         last_lat = 0;
    int         grant_log[$];

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (eg.eng_start) begin
                st_run++;
                chk("eng_x", eg.eng_x, m_x);
                chk("eng_y", eg.eng_y, m_y);
            end else if (st_run != 0) begin
                chk("start_len", st_run, SC);
                st_run   = 0;
                fall_cyc = cyc;
            end
            if (m_busy) begin
                chk("ready_busy", rq.req_ready, 0);
            end else if (rq.req_valid != '0) begin
                int p;
                p = pick(rq.req_valid, m_ptr);
                chk("grant", rq.req_ready, 1 << p);
                m_id  = p;
                m_x   = rq.req_x[p];
                m_y   = rq.req_y[p];
                m_exp = (stub_mode == M_NEVER) ? 16'h0000 : (rq.req_x[p] ^ {8'h00, rq.req_y[p]});
                m_busy = 1'b1;
                acc_count++;
                last_acc_id = p;
                acc_flag    = 1'b1;
                grant_log.push_back(p);
            end else begin
                chk("ready_idle", rq.req_ready, 0);
            end
            if (rq.rsp_valid != '0) begin
                chk("rsp_expected", m_busy, 1);
                chk("rsp_onehot", rq.rsp_valid, 1 << m_id);
                chk("rsp_ans", rq.rsp_ans, m_exp);
                chk("rsp_err", rq.rsp_err, stub_mode == M_NEVER);
                chk("rsp_lat", cyc - fall_cyc, (stub_mode == M_NEVER) ? TO + 1 : 10);
                last_rsp_valid = rq.rsp_valid;
                last_ans = rq.rsp_ans;
                last_err = rq.rsp_err;
                last_lat = cyc - fall_cyc;
                rsp_count++;
                m_ptr  = (m_id + 1) % N;
                m_busy = 1'b0;
            end else begin
                chk("rsp_quiet", {rq.rsp_ans, rq.rsp_err}, 0);
            end
        end
    end

    task automatic run_one(input int id, input q8_8_t x, input logic [7:0] y);
        int a0;
        int r0;
        int t;
        a0 = acc_count;
        r0 = rsp_count;
        @(posedge clk); #1;
        rq.req_x[id] = x;
        rq.req_y[id] = y;
        rq.req_valid[id] = 1'b1;
        t = 0;
        while (acc_count == a0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        rq.req_valid[id] = 1'b0;
        chk("accepted", acc_count - a0, 1);
        t = 0;
        while (rsp_count == r0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("responded", rsp_count - r0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req_ready"}, rq.req_ready, 0);
        chk({tag, "_rsp_valid"}, rq.rsp_valid, 0);
        chk({tag, "_rsp_ans"},   rq.rsp_ans, 0);
        chk({tag, "_rsp_err"},   rq.rsp_err, 0);
        chk({tag, "_eng_start"}, eg.eng_start, 0);
        chk({tag, "_eng_x"},     eg.eng_x, 0);
        chk({tag, "_eng_y"},     eg.eng_y, 0);
    endtask

    typedef struct {
        int          id;
        logic [15:0] x;
        logic [7:0]  y;
        int          mode;
        logic [15:0] ans;
        logic        err;
        int          lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a0;
        int r0;
        int t;
        int seen;
        int dropped;
        int exp_order[5];

        tbl[0] = '{1, 16'h010c, 8'h00, M_PULSE,  16'h010c, 1'b0, 10};
        tbl[1] = '{2, 16'h1234, 8'h5a, M_PULSE,  16'h126e, 1'b0, 10};
        tbl[2] = '{3, 16'hffff, 8'hff, M_PULSE,  16'hff00, 1'b0, 10};
        tbl[3] = '{0, 16'h8001, 8'h01, M_STICKY, 16'h8000, 1'b0, 10};
        tbl[4] = '{2, 16'h00a5, 8'h3c, M_STICKY, 16'h0099, 1'b0, 10};
        tbl[5] = '{1, 16'h4242, 8'h42, M_NEVER,  16'h0000, 1'b1, 65};
        tbl[6] = '{1, 16'h0f0f, 8'hf0, M_PULSE,  16'h0fff, 1'b0, 10};
        exp_order = '{0, 1, 2, 3, 0};

        rq.req_valid = '0;
        rq.req_x     = '0;
        rq.req_y     = '0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int r = 0; r < 7; r++) begin
            stub_mode = tbl[r].mode;
            run_one(tbl[r].id, tbl[r].x, tbl[r].y);
            chk($sformatf("v%0d_rsp_valid", r), last_rsp_valid, 1 << tbl[r].id);
            chk($sformatf("v%0d_rsp_ans", r),   last_ans, tbl[r].ans);
            chk($sformatf("v%0d_rsp_err", r),   last_err, tbl[r].err);
            chk($sformatf("v%0d_latency", r),   last_lat, tbl[r].lat);
        end

        // Reset while in WAIT: job dropped, pointer back to 0.
        stub_mode = M_PULSE;
        a0 = acc_count;
        @(posedge clk); #1;
        rq.req_x[2] = 16'h2222;
        rq.req_y[2] = 8'h22;
        rq.req_valid[2] = 1'b1;
        t = 0;
        while (acc_count == a0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        rq.req_valid[2] = 1'b0;
        chk("mid_accepted", acc_count - a0, 1);
        repeat (SC + 4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (rq.rsp_valid != '0 || eg.eng_start) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);

        // Fairness after reset: all four hold valid continuously.
        m_ptr  = 0;
        m_busy = 1'b0;
        st_run = 0;
        acc_flag = 1'b0;
        grant_log.delete();
        a0 = acc_count;
        r0 = rsp_count;
        @(posedge clk); #1;
        mon_en = 1'b1;
        rq.req_x[0] = 16'h0191;
        rq.req_x[1] = 16'h00c8;
        rq.req_x[2] = 16'h0324;
        rq.req_x[3] = 16'h00a0;
        rq.req_y = '0;
        rq.req_valid = 4'b1111;
        @(negedge clk);
        chk("post_rst_grant", rq.req_ready, 4'b0001);
        t = 0;
        while (acc_count < a0 + 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        rq.req_valid = '0;
        t = 0;
        while (rsp_count < r0 + 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("fair_rsp_count", rsp_count - r0, 5);
        chk("fair_log_size", grant_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair_order_%0d", i),
                (i < grant_log.size()) ? grant_log[i] : -1, exp_order[i]);
        end

        // Randomized traffic against the model, pulse then sticky done.
        for (int ph = 0; ph < 2; ph++) begin
            stub_mode = (ph == 0) ? M_PULSE : M_STICKY;
            acc_flag  = 1'b0;
            for (int c = 0; c < 300; c++) begin
                @(posedge clk); #1;
                dropped = -1;
                if (acc_flag) begin
                    rq.req_valid[last_acc_id] = 1'b0;
                    dropped  = last_acc_id;
                    acc_flag = 1'b0;
                end
                for (int i = 0; i < N; i++) begin
                    if (!rq.req_valid[i] && i != dropped && $urandom_range(0, 3) == 0) begin
                        rq.req_x[i] = q8_8_t'($urandom);
                        rq.req_y[i] = 8'($urandom);
                        rq.req_valid[i] = 1'b1;
                    end
                end
            end
            t = 0;
            while ((rq.req_valid != '0 || m_busy) && t < 1000) begin
                @(posedge clk); #1;
                if (acc_flag) begin
                    rq.req_valid[last_acc_id] = 1'b0;
                    acc_flag = 1'b0;
                end
                t++;
            end
            chk($sformatf("rand%0d_drained", ph), (rq.req_valid == '0) && !m_busy, 1);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ca6_sched.md
# ca6_sched

Round-robin scheduler that shares one ca6 series-evaluation engine (Q8.8 input `x`, 8-bit `y`, 16-bit `ans`, `start`/`done` handshake) among `N` requesters. It accepts one request at a time and drives the engine's start pulse. It then waits for the engine's done edge, with a timeout, and returns the result to the requester that issued it. It sits between the requester fabric and a single ca6 instance.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `START_CYCLES`, default 2: number of cycles `eng_start` is held high.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before the scheduler reports an error.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  N  per-requester request.
- `req_x`  in  N×16  per-requester Q8.8 operand.
- `req_y`  in  N×8  per-requester auxiliary operand.
- `req_ready`  out  N  one-hot grant; a request is accepted when `req_valid[i] & req_ready[i]`.
- `rsp_valid`  out  N  one-hot, one-cycle response strobe.
- `rsp_ans`  out  16  result, valid only while `rsp_valid` is nonzero.
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`.
- `eng_start`  out  1  engine start.
- `eng_x`  out  16  engine operand.
- `eng_y`  out  8  engine operand.
- `eng_ans`  in  16  engine result.
- `eng_done`  in  1  engine done; may stay high (sticky) until the next start.

## Operation
- States: IDLE, START, WAIT, RESP.
- **IDLE**
  - Grant goes to the lowest index `i` at or after `rr_ptr`, with wrap-around, such that `req_valid[i]` is high.
  - `req_ready[i]` is driven high combinationally in the same cycle.
  - On acceptance: latch `x`, `y` and id, then go to START.
  - `req_ready` is 0 in every other state.
- **START**
  - `eng_start` is 1 for exactly `START_CYCLES` cycles, then the FSM moves to WAIT.
  - `eng_x` and `eng_y` hold the latched operands from START entry until RESP exit.
- **WAIT**
  - `eng_start` is 0.
  - Completion is a rising edge of `eng_done`: `eng_done` was registered low in the previous cycle and is high now. A stale high `eng_done` is ignored.
  - On the edge: capture `eng_ans` and go to RESP with err = 0.
  - If the wait counter reaches `TIMEOUT` with no edge: go to RESP with err = 1 and ans = 16'h0000.
- **RESP**
  - `rsp_valid[id]` = 1 for one cycle; `rsp_ans` and `rsp_err` are driven.
  - `rr_ptr` ← (id+1) mod N.
  - Then return to IDLE.
- Outside RESP, `rsp_valid` = 0 and `rsp_ans`/`rsp_err` are 0.
- Widths:
  - id and `rr_ptr` are `$clog2(N)` bits.
  - Start counter is `$clog2(START_CYCLES+1)` bits.
  - Wait counter is `$clog2(TIMEOUT+1)` bits and saturates.
  - No arithmetic is performed on `x`, `y` or `ans`; they pass through unchanged.

## Timing
- **Reset** (`rst_n` low at a clock edge): state = IDLE, `rr_ptr` = 0, and all of the following are 0: `req_ready`, `rsp_valid`, `rsp_ans`, `rsp_err`, `eng_start`, `eng_x`, `eng_y`, and the done-edge register.
- **Reset mid-operation:** the operation is abandoned. `eng_start` is low in the cycle after the reset edge and no response is issued.
- **Latency:**
  - Accept at cycle t.
  - `eng_start` is high during t+1 … t+`START_CYCLES`.
  - WAIT begins at t+`START_CYCLES`+1.
  - A done edge sampled at cycle d gives `rsp_valid` at d+1.
  - The earliest next acceptance is d+2.
- **Timeout:** `rsp_valid` is asserted `TIMEOUT`+1 cycles after WAIT entry.
- **Simultaneous requests:** only one grant is issued per IDLE cycle. Requesters that are not granted must keep `req_valid` and their operands stable.
- **Done during START:** a `eng_done` rising edge while the FSM is in START is not a completion. The edge register still updates, so it is not re-detected in WAIT.

## Structure
- Package `ca6_pkg` holds:
  - `typedef logic [15:0] q8_8_t`
  - the state enum `sched_state_e`
  - default constants for `START_CYCLES` and `TIMEOUT`
- Sub-module `rr_arbiter`, parameterised by `N`:
  - inputs: `req` vector and `rr_ptr`
  - outputs: one-hot `grant` and the encoded index
  - combinational only
- The top level holds the FSM, the counters, the operand/id latches and the done-edge register.

## Test plan
- **Single request:** the bench engine stub returns `ans = x ^ {8'h00, y}` 10 cycles after `eng_start` falls.
  - Requester 1 sends `x = 16'h010c`, `y = 8'h00`.
  - Required: `eng_start` high for 2 cycles, `rsp_valid = 4'b0010`, `rsp_ans = 16'h010c`, `rsp_err = 0`.
- **Fairness:** all four requesters hold valid continuously with x = 16'h0191, 16'h00c8, 16'h0324, 16'h00a0.
  - Required: grant order 0,1,2,3,0 and each `rsp_ans` matches its own operand.
- **Sticky done:** the stub keeps `eng_done` high until the next start, then drops it on the first start cycle.
  - Required: the second request is not completed early, and its response arrives 10 cycles after `eng_start` falls.
- **Timeout:** the stub never asserts done, with `TIMEOUT` = 64.
  - Required: `rsp_valid` 65 cycles after WAIT entry, `rsp_err = 1`, `rsp_ans = 16'h0000`, and the next request is then served normally.
- **Reset mid-WAIT:** pull `rst_n` low for one cycle while in WAIT.
  - Required: all outputs 0 in the next cycle, no `rsp_valid`, and after reset requester 0 is granted first (`rr_ptr` = 0).
